// File: rtl/buffer_to_ddr3.sv
// buffer_to_ddr3: splits 2048-bit buffer words into 4-beat Avalon-MM write bursts at consecutive addresses.
// Optional BUFFER_TO_DDR3_STALL_COUNT_EN adds a saturating stall_count output.
module buffer_to_ddr3 #(
    parameter int SPLIT_WIDTH = 512,
    parameter int NUM_SPLITS  = 4,
    parameter int ADDR_WIDTH  = 26,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              cmd_start,
    input  logic [ADDR_WIDTH-1:0]             cmd_base_addr,
    input  logic [COUNT_WIDTH-1:0]            cmd_num_words,
    output logic                              cmd_busy,
    output logic                              cmd_done,
    input  logic [SPLIT_WIDTH*NUM_SPLITS-1:0] buffer_data,
    input  logic                              buffer_data_valid,
    output logic                              buffer_ready4_data,
    input  logic                              avl_ready,
    output logic                              avl_write_req,
    output logic                              avl_burstbegin,
    output logic [ADDR_WIDTH-1:0]             avl_addr,
    output logic [2:0]                        avl_size,
    output logic [SPLIT_WIDTH-1:0]            avl_wdata,
    output logic [SPLIT_WIDTH/8-1:0]          avl_be
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
    ,
    output logic [31:0]                       stall_count
`endif
);
    localparam int BW = $clog2(NUM_SPLITS);
    typedef enum logic [1:0] {IDLE, ARMED, BURST, DONE} state_t;
    state_t state_q, state_d;
    logic [NUM_SPLITS-1:0][SPLIT_WIDTH-1:0] hold_q, hold_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_WIDTH-1:0] left_q, left_d;
    logic start, accept, last_beat, more, xfer;
    assign start = state_q == IDLE && cmd_start;
    assign accept = state_q == BURST && avl_ready;
    assign last_beat = accept && beat_q == BW'(NUM_SPLITS - 1);
    // left_q counts words not yet fully written, including the one in flight
    assign more = left_q > COUNT_WIDTH'(1);
    assign buffer_ready4_data = state_q == ARMED || (last_beat && more);
    assign xfer = buffer_data_valid && buffer_ready4_data;
    assign cmd_busy = state_q != IDLE;
    assign cmd_done = state_q == DONE;
    assign avl_write_req = state_q == BURST;
    assign avl_burstbegin = state_q == BURST && beat_q == '0;
    assign avl_addr = addr_q;
    assign avl_size = 3'(NUM_SPLITS);
    assign avl_be = '1;
    assign avl_wdata = hold_q[beat_q];
    always_comb begin
        state_d = state_q;
        hold_d = xfer ? buffer_data : hold_q;
        beat_d = xfer ? '0 : accept ? beat_q + BW'(1) : beat_q;
        addr_d = start ? cmd_base_addr : last_beat ? addr_q + ADDR_WIDTH'(NUM_SPLITS) : addr_q;
        left_d = start ? cmd_num_words : last_beat ? left_q - COUNT_WIDTH'(1) : left_q;
        case (state_q)
            IDLE:    state_d = !cmd_start ? IDLE : cmd_num_words == '0 ? DONE : ARMED;
            ARMED:   state_d = xfer ? BURST : ARMED;
            BURST:   state_d = !last_beat ? BURST : !more ? DONE : xfer ? BURST : ARMED;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q <= IDLE;
            hold_q <= '0;
            beat_q <= '0;
            addr_q <= '0;
            left_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q <= hold_d;
            beat_q <= beat_d;
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (rstb || start)
            stall_q <= '0;
        else if (avl_write_req && !avl_ready && stall_q != '1)
            stall_q <= stall_q + 32'd1;
    end
    assign stall_count = stall_q;
`endif
endmodule

// File: tb/tb_buffer_to_ddr3.sv
// tb_buffer_to_ddr3: directed self-checking bench for buffer_to_ddr3.
module tb_buffer_to_ddr3;
    localparam int SW = 512, NS = 4, AW = 26, CW = 16;
    logic clk = 0, rstb, cmd_start, cmd_busy, cmd_done;
    logic [AW-1:0] cmd_base_addr, avl_addr;
    logic [CW-1:0] cmd_num_words;
    logic [SW*NS-1:0] buffer_data;
    logic buffer_data_valid, buffer_ready4_data, avl_ready, avl_write_req, avl_burstbegin;
    logic [2:0] avl_size;
    logic [SW-1:0] avl_wdata;
    logic [SW/8-1:0] avl_be;
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif
    int passed = 0, total = 0;

    buffer_to_ddr3 dut (
        .clk(clk), .rstb(rstb), .cmd_start(cmd_start), .cmd_base_addr(cmd_base_addr),
        .cmd_num_words(cmd_num_words), .cmd_busy(cmd_busy), .cmd_done(cmd_done),
        .buffer_data(buffer_data), .buffer_data_valid(buffer_data_valid),
        .buffer_ready4_data(buffer_ready4_data), .avl_ready(avl_ready),
        .avl_write_req(avl_write_req), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr),
        .avl_size(avl_size), .avl_wdata(avl_wdata), .avl_be(avl_be)
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] sl(input logic [31:0] b, input int k);
        return {16{b + 32'(k)}};
    endfunction

    function automatic logic [SW*NS-1:0] mk(input logic [31:0] b);
        logic [SW*NS-1:0] w;
        for (int k = 0; k < NS; k++) w[SW*k +: SW] = sl(b, k);
        return w;
    endfunction

    task automatic start_cmd(input logic [AW-1:0] base, input logic [CW-1:0] n, input logic [31:0] db);
        @(negedge clk);
        cmd_start = 1; cmd_base_addr = base; cmd_num_words = n;
        buffer_data = mk(db); buffer_data_valid = 1; avl_ready = 1;
        @(negedge clk);
        cmd_start = 0;
    endtask

    task automatic test_reset;
        rstb = 1; cmd_start = 0; cmd_base_addr = '0; cmd_num_words = '0;
        buffer_data = '0; buffer_data_valid = 0; avl_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (avl_write_req !== 1'b0) $display("FAIL rst_write_req got %b want 0", avl_write_req); else passed++;
        total++; if (buffer_ready4_data !== 1'b0) $display("FAIL rst_ready4 got %b want 0", buffer_ready4_data); else passed++;
        total++; if (cmd_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", cmd_busy); else passed++;
        total++; if (cmd_done !== 1'b0) $display("FAIL rst_done got %b want 0", cmd_done); else passed++;
        total++; if (avl_size !== 3'd4) $display("FAIL rst_size got %0d want 4", avl_size); else passed++;
        total++; if (avl_be !== {64{1'b1}}) $display("FAIL rst_be got %h want all ones", avl_be); else passed++;
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
        total++; if (stall_count !== 32'd0) $display("FAIL rst_stall got %0d want 0", stall_count); else passed++;
`endif
        @(negedge clk);
        rstb = 0;
    endtask

    task automatic test_single;
        @(negedge clk);
        cmd_start = 1; cmd_base_addr = 26'h100; cmd_num_words = 1;
        buffer_data = mk(32'hA0); buffer_data_valid = 1; avl_ready = 1;
        #1;
        total++; if (cmd_busy !== 1'b0) $display("FAIL single_idle_busy got %b want 0", cmd_busy); else passed++;
        @(negedge clk);
        cmd_start = 0;
        #1;
        total++; if (buffer_ready4_data !== 1'b1) $display("FAIL single_armed_ready got %b want 1", buffer_ready4_data); else passed++;
        total++; if (cmd_busy !== 1'b1) $display("FAIL single_armed_busy got %b want 1", cmd_busy); else passed++;
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            buffer_data_valid = 0;
            #1;
            total++; if (avl_write_req !== 1'b1) $display("FAIL single_req beat %0d got %b want 1", k, avl_write_req); else passed++;
            total++; if (avl_addr !== 26'h100) $display("FAIL single_addr beat %0d got %h want 100", k, avl_addr); else passed++;
            total++; if (avl_wdata !== sl(32'hA0, k)) $display("FAIL single_wdata beat %0d got %h want %h", k, avl_wdata[31:0], sl(32'hA0, k) & 512'hFFFFFFFF); else passed++;
            total++; if (avl_burstbegin !== (k == 0)) $display("FAIL single_bb beat %0d got %b want %b", k, avl_burstbegin, k == 0); else passed++;
        end
        @(negedge clk); #1;
        total++; if (cmd_done !== 1'b1) $display("FAIL single_done got %b want 1", cmd_done); else passed++;
        total++; if (avl_write_req !== 1'b0) $display("FAIL single_done_req got %b want 0", avl_write_req); else passed++;
        @(negedge clk); #1;
        total++; if (cmd_done !== 1'b0) $display("FAIL single_done_drop got %b want 0", cmd_done); else passed++;
        total++; if (cmd_busy !== 1'b0) $display("FAIL single_end_busy got %b want 0", cmd_busy); else passed++;
    endtask

    task automatic test_backpressure;
        logic [7:0] pat = 8'b1011_0010;
        int b = 0;
        start_cmd(26'h100, 1, 32'hA0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            buffer_data_valid = 0; avl_ready = pat[i];
            #1;
            total++; if (avl_write_req !== 1'b1) $display("FAIL bp_req cyc %0d got %b want 1", i, avl_write_req); else passed++;
            total++; if (avl_wdata !== sl(32'hA0, b)) $display("FAIL bp_wdata cyc %0d got %h want beat %0d", i, avl_wdata[31:0], b); else passed++;
            total++; if (avl_addr !== 26'h100) $display("FAIL bp_addr cyc %0d got %h want 100", i, avl_addr); else passed++;
            total++; if (avl_burstbegin !== (b == 0)) $display("FAIL bp_bb cyc %0d got %b want %b", i, avl_burstbegin, b == 0); else passed++;
            if (pat[i]) b++;
        end
        @(negedge clk); avl_ready = 1; #1;
        total++; if (cmd_done !== 1'b1) $display("FAIL bp_done got %b want 1", cmd_done); else passed++;
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
        total++; if (stall_count !== 32'd4) $display("FAIL bp_stall got %0d want 4", stall_count); else passed++;
`endif
    endtask

    task automatic test_back_to_back;
        int nx = 0, dones = 0;
        start_cmd(26'h100, 3, 32'hC0);
        for (int c = 1; c < 14; c++) begin
            if (c > 1) @(negedge clk);
            buffer_data = mk(32'hC0 + 32'(4 * nx));
            #1;
            if (c >= 2) begin
                int i = c - 2, w = (c - 2) / 4, k = (c - 2) % 4;
                total++; if (avl_write_req !== 1'b1) $display("FAIL b2b_req cyc %0d got %b want 1", i, avl_write_req); else passed++;
                total++; if (avl_addr !== 26'(32'h100 + 4 * w)) $display("FAIL b2b_addr cyc %0d got %h want %h", i, avl_addr, 32'h100 + 4 * w); else passed++;
                total++; if (avl_wdata !== sl(32'hC0 + 32'(4 * w), k)) $display("FAIL b2b_wdata cyc %0d got %h", i, avl_wdata[31:0]); else passed++;
                total++; if (avl_burstbegin !== (k == 0)) $display("FAIL b2b_bb cyc %0d got %b want %b", i, avl_burstbegin, k == 0); else passed++;
            end
            if (buffer_ready4_data && buffer_data_valid) nx++;
        end
        total++; if (nx !== 3) $display("FAIL b2b_transfers got %0d want 3", nx); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); buffer_data_valid = (c == 0); #1;
            if (cmd_done) dones++;
            total++; if (avl_write_req !== 1'b0) $display("FAIL b2b_tail_req cyc %0d got %b want 0", c, avl_write_req); else passed++;
        end
        total++; if (dones !== 1) $display("FAIL b2b_done_pulses got %0d want 1", dones); else passed++;
`ifdef BUFFER_TO_DDR3_STALL_COUNT_EN
        total++; if (stall_count !== 32'd0) $display("FAIL b2b_stall_cleared got %0d want 0", stall_count); else passed++;
`endif
        buffer_data_valid = 0;
    endtask

    task automatic test_zero_count;
        start_cmd(26'h40, 0, 32'h11);
        buffer_data_valid = 0;
        #1;
        total++; if (cmd_done !== 1'b1) $display("FAIL zero_done got %b want 1", cmd_done); else passed++;
        total++; if (avl_write_req !== 1'b0) $display("FAIL zero_req got %b want 0", avl_write_req); else passed++;
        total++; if (cmd_busy !== 1'b1) $display("FAIL zero_busy got %b want 1", cmd_busy); else passed++;
        @(negedge clk); #1;
        total++; if (cmd_done !== 1'b0) $display("FAIL zero_done_drop got %b want 0", cmd_done); else passed++;
        total++; if (avl_write_req !== 1'b0) $display("FAIL zero_req_after got %b want 0", avl_write_req); else passed++;
    endtask

    task automatic test_start_ignored;
        start_cmd(26'h200, 1, 32'hE0);
        for (int k = 0; k < NS; k++) begin
            @(negedge clk);
            buffer_data_valid = 0; cmd_start = (k == 1); cmd_base_addr = 26'h300; cmd_num_words = 5;
            #1;
            total++; if (avl_addr !== 26'h200) $display("FAIL ign_addr beat %0d got %h want 200", k, avl_addr); else passed++;
            total++; if (avl_wdata !== sl(32'hE0, k)) $display("FAIL ign_wdata beat %0d got %h", k, avl_wdata[31:0]); else passed++;
        end
        @(negedge clk); cmd_start = 0; #1;
        total++; if (cmd_done !== 1'b1) $display("FAIL ign_done got %b want 1", cmd_done); else passed++;
        @(negedge clk); #1;
        total++; if (avl_write_req !== 1'b0) $display("FAIL ign_req_after got %b want 0", avl_write_req); else passed++;
        total++; if (cmd_busy !== 1'b0) $display("FAIL ign_busy_after got %b want 0", cmd_busy); else passed++;
    endtask

    task automatic test_reset_mid;
        start_cmd(26'h100, 2, 32'hA0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            buffer_data_valid = 0; rstb = (k == 2);
        end
        #1;
        total++; if (avl_wdata !== sl(32'hA0, 2)) $display("FAIL rmid_beat2 got %h", avl_wdata[31:0]); else passed++;
        @(negedge clk); rstb = 0; #1;
        total++; if (avl_write_req !== 1'b0) $display("FAIL rmid_req got %b want 0", avl_write_req); else passed++;
        total++; if (cmd_busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", cmd_busy); else passed++;
        total++; if (buffer_ready4_data !== 1'b0) $display("FAIL rmid_ready got %b want 0", buffer_ready4_data); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++; if (cmd_done !== 1'b0) $display("FAIL rmid_done cyc %0d got %b want 0", c, cmd_done); else passed++;
        end
    endtask

    task automatic test_wrap;
        start_cmd(26'h3FFFFFC, 2, 32'h55);
        for (int c = 2; c < 10; c++) begin
            @(negedge clk); #1;
            total++; if (avl_write_req !== 1'b1) $display("FAIL wrap_req cyc %0d got %b want 1", c, avl_write_req); else passed++;
            total++; if (avl_addr !== (c < 6 ? 26'h3FFFFFC : 26'h0)) $display("FAIL wrap_addr cyc %0d got %h", c, avl_addr); else passed++;
        end
        @(negedge clk); buffer_data_valid = 0; #1;
        total++; if (cmd_done !== 1'b1) $display("FAIL wrap_done got %b want 1", cmd_done); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_zero_count;
        test_start_ignored;
        test_reset_mid;
        test_wrap;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
